// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite initiator: state encoding, response codes, PROT default.
package axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_RSP
   } axil_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_wdog.sv
// Watchdog for stalled AXI transfers: counts enabled cycles since the last clear and
// pulses timeout once on reaching C_TIMEOUT (C_TIMEOUT = 0 never fires).
module axil_wdog #(
   parameter int unsigned C_TIMEOUT = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int unsigned CW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT    = CW'(C_TIMEOUT);
   localparam logic [CW-1:0] LIMIT_M1 = CW'(C_TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Counter saturates at LIMIT so the pulse fires once per stall, until the next clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (clear) begin
            cnt <= '0;
         end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
            if (cnt == LIMIT_M1) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or write out,
// one response back. All AXI and response outputs come straight from flops.
module axil_master
   import axil_pkg::*;
#(
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
   parameter int unsigned C_TIMEOUT          = 1024
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   axil_state_t state, state_next;
   logic        aw_done, aw_done_next;
   logic        w_done, w_done_next;
   logic        accept, b_hs, r_hs;
   logic        wdog_clear, wdog_enable;

   assign M_AXI_AWPROT = PROT_DEFAULT;
   assign M_AXI_ARPROT = PROT_DEFAULT;

   assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;
   assign b_hs   = (state == ST_WR_RESP) && M_AXI_BVALID && M_AXI_BREADY;
   assign r_hs   = (state == ST_RD_RESP) && M_AXI_RVALID && M_AXI_RREADY;

   always_comb begin
      state_next   = state;
      aw_done_next = aw_done;
      w_done_next  = w_done;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next   = cmd_write ? ST_WR_REQ : ST_RD_REQ;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
            end
         end
         ST_WR_REQ: begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_next = 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY)   w_done_next  = 1'b1;
            if (aw_done_next && w_done_next)    state_next   = ST_WR_RESP;
         end
         ST_WR_RESP: if (b_hs) state_next = ST_RSP;
         ST_RD_REQ:  if (M_AXI_ARVALID && M_AXI_ARREADY) state_next = ST_RD_RESP;
         ST_RD_RESP: if (r_hs) state_next = ST_RSP;
         ST_RSP:     if (rsp_valid && rsp_ready) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so each VALID/READY
   // appears the cycle the state is entered and drops right after its handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         cmd_ready     <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         rsp_valid     <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_ARADDR  <= '0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= '0;
      end else begin
         state         <= state_next;
         aw_done       <= aw_done_next;
         w_done        <= w_done_next;
         cmd_ready     <= (state_next == ST_IDLE);
         M_AXI_AWVALID <= (state_next == ST_WR_REQ) && !aw_done_next;
         M_AXI_WVALID  <= (state_next == ST_WR_REQ) && !w_done_next;
         M_AXI_BREADY  <= (state_next == ST_WR_RESP);
         M_AXI_ARVALID <= (state_next == ST_RD_REQ);
         M_AXI_RREADY  <= (state_next == ST_RD_RESP);
         rsp_valid     <= (state_next == ST_RSP);
         if (accept) begin
            M_AXI_AWADDR <= cmd_addr;
            M_AXI_ARADDR <= cmd_addr;
            M_AXI_WDATA  <= cmd_wdata;
            M_AXI_WSTRB  <= cmd_wstrb;
         end
         if (b_hs) begin
            rsp_rdata <= '0;
            rsp_resp  <= M_AXI_BRESP;
         end
         if (r_hs) begin
            rsp_rdata <= M_AXI_RDATA;
            rsp_resp  <= M_AXI_RRESP;
         end
      end
   end

   assign wdog_clear  = (state_next != state);
   assign wdog_enable = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                        (state == ST_RD_REQ) || (state == ST_RD_RESP);

   axil_wdog #(
      .C_TIMEOUT (C_TIMEOUT)
   ) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wdog_clear),
      .enable  (wdog_enable),
      .timeout (timeout)
   );

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: the bench plays the AXI slave cycle by cycle.
module tb_axil_master;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        timeout;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int total = 0;
   int bad   = 0;
   int b_hs_cnt = 0;
   int rsp_hs_cnt = 0;

   axil_master #(
      .C_M_AXI_DATA_WIDTH (32),
      .C_M_AXI_ADDR_WIDTH (4),
      .C_TIMEOUT          (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .timeout       (timeout),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWPROT  (awprot),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) begin
      if (bvalid && bready) b_hs_cnt++;
      if (rsp_valid && rsp_ready) rsp_hs_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL global_time_limit got=expired exp=finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
      total++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin bad++; $display("FAIL rst_axi_hs got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); end
      total++; if ({rsp_valid, timeout} !== 2'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", {rsp_valid, timeout}); end
      total++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin bad++; $display("FAIL rst_rsp_payload got=%h/%b exp=0/00", rsp_rdata, rsp_resp); end
      total++; if (awprot !== 3'b000 || arprot !== 3'b000) begin bad++; $display("FAIL rst_prot got=%b/%b exp=000/000", awprot, arprot); end
      tick;
      reset = 1'b0;
      tick;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_read_backpressure;
      arready = 1'b1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC;
      tick;
      cmd_valid = 1'b0;
      total++; if (arvalid !== 1'b1 || araddr !== 4'hC) begin bad++; $display("FAIL rd_arvalid got=%b/%h exp=1/c", arvalid, araddr); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rd_cmd_ready_busy got=%b exp=0", cmd_ready); end
      tick;
      arready = 1'b0;
      total++; if (arvalid !== 1'b0 || rready !== 1'b1) begin bad++; $display("FAIL rd_after_ar got=%b%b exp=01", arvalid, rready); end
      tick;
      tick;
      total++; if (rready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_wait_r got=%b%b exp=10", rready, rsp_valid); end
      rvalid = 1'b1; rdata = 32'h0000_00A5; rresp = 2'b10;
      tick;
      rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
      total++; if (rready !== 1'b0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%b%b exp=01", rready, rsp_valid); end
      total++; if (rsp_rdata !== 32'h0000_00A5 || rsp_resp !== 2'b10) begin bad++; $display("FAIL rd_rsp_payload got=%h/%b exp=000000a5/10", rsp_rdata, rsp_resp); end
      cmd_valid = 1'b1; cmd_addr = 4'h8;
      for (int i = 0; i < 5; i++) begin
         tick;
         total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00A5 || rsp_resp !== 2'b10) begin bad++; $display("FAIL rd_stall_stable[%0d] got=%b/%h/%b exp=1/000000a5/10", i, rsp_valid, rsp_rdata, rsp_resp); end
         total++; if (cmd_ready !== 1'b0 || arvalid !== 1'b0) begin bad++; $display("FAIL rd_stall_no_accept[%0d] got=%b%b exp=00", i, cmd_ready, arvalid); end
      end
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      tick;
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL rd_rsp_done got=%b%b%b exp=010", rsp_valid, cmd_ready, arvalid); end
   endtask

   task automatic test_write_basic;
      awready = 1'b1; wready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h3; cmd_wstrb = 4'hF;
      tick;
      cmd_valid = 1'b0;
      total++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin bad++; $display("FAIL wr_valids got=%b%b exp=11", awvalid, wvalid); end
      total++; if (awaddr !== 4'h0 || wdata !== 32'h3 || wstrb !== 4'hF) begin bad++; $display("FAIL wr_payload got=%h/%h/%h exp=0/00000003/f", awaddr, wdata, wstrb); end
      tick;
      total++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin bad++; $display("FAIL wr_after_hs got=%b%b%b exp=001", awvalid, wvalid, bready); end
      bvalid = 1'b1; bresp = 2'b00;
      tick;
      bvalid = 1'b0;
      total++; if (bready !== 1'b0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid got=%b%b exp=01", bready, rsp_valid); end
      total++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin bad++; $display("FAIL wr_rsp_payload got=%h/%b exp=00000000/00", rsp_rdata, rsp_resp); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_done got=%b%b exp=01", rsp_valid, cmd_ready); end
   endtask

   task automatic test_write_aw_delay;
      int b0, r0;
      b0 = b_hs_cnt; r0 = rsp_hs_cnt;
      awready = 1'b0; wready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'h3;
      tick;
      cmd_valid = 1'b0;
      total++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin bad++; $display("FAIL awd_valids got=%b%b exp=11", awvalid, wvalid); end
      tick;
      total++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin bad++; $display("FAIL awd_w_dropped got=%b%b%b exp=010", wvalid, awvalid, bready); end
      tick;
      total++; if (awvalid !== 1'b1 || awaddr !== 4'h4) begin bad++; $display("FAIL awd_hold2 got=%b/%h exp=1/4", awvalid, awaddr); end
      tick;
      total++; if (awvalid !== 1'b1 || wvalid !== 1'b0) begin bad++; $display("FAIL awd_hold3 got=%b%b exp=10", awvalid, wvalid); end
      awready = 1'b1;
      tick;
      awready = 1'b0;
      total++; if (awvalid !== 1'b0 || bready !== 1'b1) begin bad++; $display("FAIL awd_after_aw got=%b%b exp=01", awvalid, bready); end
      bvalid = 1'b1; bresp = 2'b11;
      tick;
      total++; if (bready !== 1'b0 || rsp_valid !== 1'b1 || rsp_resp !== 2'b11) begin bad++; $display("FAIL awd_rsp got=%b%b/%b exp=01/11", bready, rsp_valid, rsp_resp); end
      tick;
      bvalid = 1'b0;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      tick;
      total++; if (b_hs_cnt - b0 !== 1) begin bad++; $display("FAIL awd_b_count got=%0d exp=1", b_hs_cnt - b0); end
      total++; if (rsp_hs_cnt - r0 !== 1) begin bad++; $display("FAIL awd_rsp_count got=%0d exp=1", rsp_hs_cnt - r0); end
   endtask

   task automatic test_timeout;
      int pulses;
      pulses = 0;
      awready = 1'b1; wready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'hCAFE_0001; cmd_wstrb = 4'h1;
      tick;
      cmd_valid = 1'b0;
      tick;
      awready = 1'b0; wready = 1'b0;
      total++; if (bready !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL to_enter got=%b%b exp=10", bready, timeout); end
      for (int k = 1; k <= 12; k++) begin
         tick;
         if (timeout === 1'b1) pulses++;
         total++; if (timeout !== (k == 8)) begin bad++; $display("FAIL to_pulse[%0d] got=%b exp=%b", k, timeout, (k == 8)); end
         total++; if (bready !== 1'b1) begin bad++; $display("FAIL to_bready[%0d] got=%b exp=1", k, bready); end
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL to_pulse_count got=%0d exp=1", pulses); end
      bvalid = 1'b1; bresp = 2'b01;
      tick;
      bvalid = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b01 || timeout !== 1'b0) begin bad++; $display("FAIL to_late_b got=%b/%b/%b exp=1/01/0", rsp_valid, rsp_resp, timeout); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_reset_midread;
      arready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
      tick;
      cmd_valid = 1'b0;
      total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL mr_arvalid got=%b exp=1", arvalid); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (arvalid !== 1'b0 || cmd_ready !== 1'b0 || rready !== 1'b0) begin bad++; $display("FAIL mr_async_drop got=%b%b%b exp=000", arvalid, cmd_ready, rready); end
      tick;
      reset = 1'b0;
      arready = 1'b1;
      tick;
      total++; if (cmd_ready !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL mr_release got=%b%b exp=10", cmd_ready, arvalid); end
      for (int i = 0; i < 4; i++) begin
         tick;
         total++; if (rsp_valid !== 1'b0 || rready !== 1'b0) begin bad++; $display("FAIL mr_no_stale[%0d] got=%b%b exp=00", i, rsp_valid, rready); end
      end
      arready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
      test_reset();
      test_read_backpressure();
      test_write_basic();
      test_write_aw_delay();
      test_timeout();
      test_reset_midread();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- Single-outstanding AXI4-Lite initiator: the master counterpart to the team's AXI-Lite slave register interface.
- Converts one command from a simple valid/ready command port into one AXI4-Lite read or write, and returns the result on a response port.
- Used to drive the UART IP register map from on-chip logic and as the master model in the uart_ip system bench.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 4, address width; matches the UART IP register map.
- C_TIMEOUT, 1024, wait cycles before the watchdog flag fires; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as returned.
- timeout  out  1  one-cycle pulse when the watchdog expires.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels at the widths above.

Behaviour:
- Reset: all outputs 0 (cmd_ready 0 during reset), state IDLE. Assertion mid-transaction drops every VALID/READY immediately; no response is produced for the aborted command.
- All AXI and rsp outputs are registered. AWPROT and ARPROT are fixed at 3'b000.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. Accepting a write latches addr/wdata/wstrb and goes to WR_REQ. Accepting a read latches addr and goes to RD_REQ.
- WR_REQ: AWVALID and WVALID both rise the cycle after accept. Each drops the cycle after its own handshake. AW-first, W-first and same-cycle handshakes are all legal. Move to WR_RESP once both have handshaken.
- WR_RESP: BREADY=1. On BVALID&BREADY, capture BRESP, set rsp_rdata=0, go to RSP. A BVALID already high on entry completes in the entry cycle.
- RD_REQ: ARVALID=1 until the ARREADY handshake, then RD_RESP.
- RD_RESP: RREADY=1. On RVALID&RREADY, capture RDATA/RRESP and go to RSP.
- RSP: rsp_valid=1, payload stable until rsp_ready. After the handshake, IDLE next cycle; cmd_ready rises then.
- VALID rule: once asserted, a VALID never drops before its READY, and its payload is stable.
- Minimum latency with always-ready slave: accept at N, AW/W handshake N+1, B at N+2, rsp_valid N+3. Reads have the same timing.
- Watchdog: counter clears on every state change and counts while in WR_REQ, WR_RESP, RD_REQ or RD_RESP. At C_TIMEOUT it pulses timeout once and holds until the next state change. The transaction is never abandoned, because AXI forbids withdrawing VALID.
- No error interpretation: SLVERR and DECERR pass through unchanged on rsp_resp.

Decomposition:
- Shared package axil_pkg:
  - State encoding constants.
  - RESP codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Default PROT constant.
- One sub-module, axil_wdog:
  - Inputs: clear, enable.
  - Output: timeout pulse.
  - Parameter: C_TIMEOUT.

Test Plan:
- Write addr 0x0, wdata 0x3, wstrb 0xF, slave always ready -> AWADDR=0x0, WDATA=0x3 handshake at N+1; rsp_valid at N+3 with rsp_resp=00 and rsp_rdata=0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops at N+2, AWVALID held to N+4, exactly one B accepted, one response.
- Read addr 0xC, slave returns RDATA 0x000000A5 with RRESP=10 after 2-cycle RVALID delay -> rsp_rdata=0xA5, rsp_resp=10.
- rsp_ready held low 5 cycles -> rsp_valid and payload stable; cmd_ready stays low; accepted only after the handshake.
- C_TIMEOUT=8, slave never asserts BVALID -> timeout pulses once after 8 cycles in WR_RESP; BREADY remains 1; a late BVALID still completes.
- Reset asserted while ARVALID=1 -> ARVALID=0 asynchronously; after release cmd_ready=1 and no stale rsp_valid appears.
